// File: rtl/md_msg_decoder.sv
// Market-data datagram decoder: splits UDP payloads into 18-byte messages and queues them in a FIFO.
// Optional sequence-gap detection is enabled by defining MD_SEQ_GAP_CHECK_EN.
module md_msg_decoder #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_seq,
    output logic [7:0]  out_type,
    output logic [7:0]  out_side,
    output logic [31:0] out_order_id,
    output logic [31:0] out_price,
    output logic [31:0] out_qty,
    output logic [15:0] out_sym,
    output logic [15:0] drop_cnt,
    output logic [15:0] trunc_cnt,
    output logic [15:0] gap_cnt,
    output logic        gap_pulse
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned EntryW = 160;

    typedef enum logic [1:0] {StIdle, StHdr, StMsg, StDrain} state_e;

    state_e        state_q, state_d;
    logic [2:0]    hdr_idx_q;
    logic [4:0]    byte_idx_q;
    logic [15:0]   msg_idx_q;
    logic [15:0]   msg_count_q;
    logic [31:0]   seq_q;
    logic [127:0]  body_q;
    logic [15:0]   count_now;
    logic          msg_done;
    logic          trunc_evt;
    logic          hdr_last;

    assign count_now = {msg_count_q[7:0], in_data};
    assign hdr_last  = in_valid && (state_q == StHdr) && (hdr_idx_q == 3'd5);

    always_comb begin
        state_d   = state_q;
        msg_done  = 1'b0;
        trunc_evt = 1'b0;
        if (!in_valid) begin
            state_d   = StIdle;
            trunc_evt = (state_q == StHdr) || ((state_q == StMsg) && (byte_idx_q != 5'd0));
        end else begin
            unique case (state_q)
                StIdle: state_d = StHdr;
                StHdr: begin
                    if (hdr_idx_q == 3'd5) begin
                        state_d = (count_now == 16'd0) ? StDrain : StMsg;
                    end
                end
                StMsg: begin
                    if (byte_idx_q == 5'd17) begin
                        msg_done = 1'b1;
                        if (msg_idx_q + 16'd1 == msg_count_q) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: state_d = StDrain;
                default: state_d = StIdle;
            endcase
        end
    end

    // Bytes 16-17 of each message are reserved; only bytes 0-15 are captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            hdr_idx_q   <= 3'd0;
            byte_idx_q  <= 5'd0;
            msg_idx_q   <= 16'd0;
            msg_count_q <= 16'd0;
            seq_q       <= 32'd0;
            body_q      <= 128'd0;
        end else begin
            state_q <= state_d;
            if (in_valid) begin
                unique case (state_q)
                    StIdle: begin
                        seq_q     <= {seq_q[23:0], in_data};
                        hdr_idx_q <= 3'd1;
                    end
                    StHdr: begin
                        hdr_idx_q <= hdr_idx_q + 3'd1;
                        if (hdr_idx_q < 3'd4) begin
                            seq_q <= {seq_q[23:0], in_data};
                        end else begin
                            msg_count_q <= count_now;
                        end
                        if (hdr_idx_q == 3'd5) begin
                            byte_idx_q <= 5'd0;
                            msg_idx_q  <= 16'd0;
                        end
                    end
                    StMsg: begin
                        if (byte_idx_q < 5'd16) begin
                            body_q <= {body_q[119:0], in_data};
                        end
                        if (byte_idx_q == 5'd17) begin
                            byte_idx_q <= 5'd0;
                            msg_idx_q  <= msg_idx_q + 16'd1;
                        end else begin
                            byte_idx_q <= byte_idx_q + 5'd1;
                        end
                    end
                    StDrain: ;
                    default: ;
                endcase
            end
        end
    end

    logic [EntryW-1:0] mem [FIFO_DEPTH];
    logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
    logic              fifo_full, fifo_empty, push, pop;
    logic [EntryW-1:0] wdata, head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // Fullness is judged before any same-cycle pop.
    assign push       = msg_done && !fifo_full;
    assign pop        = !fifo_empty && out_ready;
    assign wdata      = {seq_q + {16'd0, msg_idx_q}, body_q};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[PtrW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage is not reset, so fields are forced to zero while the FIFO is empty.
    assign head         = fifo_empty ? '0 : mem[rd_ptr_q[PtrW-1:0]];
    assign out_valid    = !fifo_empty;
    assign out_seq      = head[159:128];
    assign out_type     = head[127:120];
    assign out_side     = head[119:112];
    assign out_order_id = head[111:80];
    assign out_price    = head[79:48];
    assign out_qty      = head[47:16];
    assign out_sym      = head[15:0];

    logic [15:0] drop_cnt_q, trunc_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q  <= 16'd0;
            trunc_cnt_q <= 16'd0;
        end else begin
            if (msg_done && fifo_full && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (trunc_evt && (trunc_cnt_q != 16'hFFFF)) begin
                trunc_cnt_q <= trunc_cnt_q + 16'd1;
            end
        end
    end

    assign drop_cnt  = drop_cnt_q;
    assign trunc_cnt = trunc_cnt_q;

`ifdef MD_SEQ_GAP_CHECK_EN
    logic [31:0] exp_seq_q;
    logic        exp_valid_q;
    logic        gap_pulse_q;
    logic [15:0] gap_cnt_q;
    logic        gap_hit;

    assign gap_hit = in_valid && (state_q == StHdr) && (hdr_idx_q == 3'd3) && exp_valid_q &&
                     ({seq_q[23:0], in_data} != exp_seq_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_seq_q   <= 32'd0;
            exp_valid_q <= 1'b0;
            gap_pulse_q <= 1'b0;
            gap_cnt_q   <= 16'd0;
        end else begin
            gap_pulse_q <= gap_hit;
            if (gap_hit && (gap_cnt_q != 16'hFFFF)) begin
                gap_cnt_q <= gap_cnt_q + 16'd1;
            end
            if (hdr_last) begin
                exp_seq_q   <= seq_q + {16'd0, count_now};
                exp_valid_q <= 1'b1;
            end
        end
    end

    assign gap_pulse = gap_pulse_q;
    assign gap_cnt   = gap_cnt_q;
`else
    logic unused_hdr_last;
    assign unused_hdr_last = hdr_last;
    assign gap_pulse       = 1'b0;
    assign gap_cnt         = 16'd0;
`endif

endmodule

// File: tb/tb_md_msg_decoder.sv
// Scoreboard bench for md_msg_decoder: directed scenarios plus randomized datagrams.
module tb_md_msg_decoder;

    localparam int Depth = 4;
`ifdef MD_SEQ_GAP_CHECK_EN
    localparam bit GapEn = 1'b1;
`else
    localparam bit GapEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, out_valid, out_ready, gap_pulse;
    logic [7:0]  in_data, out_type, out_side;
    logic [31:0] out_seq, out_order_id, out_price, out_qty;
    logic [15:0] out_sym, drop_cnt, trunc_cnt, gap_cnt;

    md_msg_decoder #(.FIFO_DEPTH(Depth)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq), .out_type(out_type),
        .out_side(out_side), .out_order_id(out_order_id), .out_price(out_price),
        .out_qty(out_qty), .out_sym(out_sym), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt),
        .gap_cnt(gap_cnt), .gap_pulse(gap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] seq;
        logic [7:0]  typ;
        logic [7:0]  side;
        logic [31:0] oid;
        logic [31:0] price;
        logic [31:0] qty;
        logic [15:0] sym;
    } msg_t;

    msg_t        sb[$];
    int          checks = 0, passes = 0;
    int          exp_drop = 0, exp_trunc = 0, exp_gap = 0, gap_pulses = 0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_seq = 32'd0;
    bit          lat_pending = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: compare the head every valid cycle; retire it when the consumer accepts.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 160'(out_valid), 160'd0);
            end else begin
                check("msg", {out_seq, out_type, out_side, out_order_id, out_price, out_qty,
                              out_sym}, sb[0]);
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (!reset && gap_pulse) gap_pulses++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (lat_pending) begin
            check("latency", 160'(out_valid), 160'd1);
            lat_pending = 1'b0;
        end
        in_valid = v;
        in_data  = d;
    endtask

    // cut < 0 sends the whole datagram; otherwise only the first cut bytes.
    task automatic send_dgram(input logic [31:0] seq, input int count, input int cut,
                              input int extra, input int gap);
        logic [7:0]   bq[$];
        msg_t         mq[$];
        msg_t         m;
        logic [127:0] body;
        logic [15:0]  c16;
        int           len, nfull, k;
        c16 = count[15:0];
        bq.push_back(seq[31:24]); bq.push_back(seq[23:16]);
        bq.push_back(seq[15:8]);  bq.push_back(seq[7:0]);
        bq.push_back(c16[15:8]);  bq.push_back(c16[7:0]);
        for (int j = 0; j < count; j++) begin
            m.seq   = seq + 32'(j);
            m.typ   = 8'($urandom);
            m.side  = 8'($urandom);
            m.oid   = $urandom;
            m.price = $urandom;
            m.qty   = $urandom;
            m.sym   = 16'($urandom);
            body    = {m.typ, m.side, m.oid, m.price, m.qty, m.sym};
            for (int i = 0; i < 16; i++) bq.push_back(body[127-8*i -: 8]);
            bq.push_back(8'($urandom));
            bq.push_back(8'($urandom));
            mq.push_back(m);
        end
        for (int i = 0; i < extra; i++) bq.push_back(8'($urandom));
        if (cut >= 0) while (bq.size() > cut) void'(bq.pop_back());
        len = bq.size();
        for (int p = 0; p < len; p++) begin
            drive(1'b1, bq[p]);
            if (p == 3 && GapEn && exp_valid && seq != exp_seq) exp_gap++;
            if (p == 5) begin
                exp_seq   = seq + 32'(count);
                exp_valid = 1'b1;
            end
            if (p >= 6 && (p - 6) % 18 == 17 && (p - 6) / 18 < count) begin
                k = (p - 6) / 18;
                if (sb.size() >= Depth) begin
                    exp_drop++;
                end else begin
                    if (sb.size() == 0) lat_pending = 1'b1;
                    sb.push_back(mq[k]);
                end
            end
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 8'd0);
        if (len > 0 && len < 6) exp_trunc++;
        else if (len >= 6) begin
            nfull = (len - 6) / 18;
            if (nfull < count && (len - 6) % 18 != 0) exp_trunc++;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) drive(1'b0, 8'd0);
        check("drain", 160'(sb.size()), 160'd0);
        drive(1'b0, 8'd0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_drop"}, 160'(drop_cnt), 160'(exp_drop));
        check({tag, "_trunc"}, 160'(trunc_cnt), 160'(exp_trunc));
        check({tag, "_gap"}, 160'(gap_cnt), 160'(exp_gap));
        check({tag, "_gap_pulses"}, 160'(gap_pulses), 160'(exp_gap));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 160'(out_valid), 160'd0);
        check({tag, "_fields"}, {out_seq, out_type, out_side, out_order_id, out_price, out_qty,
                                 out_sym}, 160'd0);
        check({tag, "_pulse"}, 160'(gap_pulse), 160'd0);
        check_counters(tag);
    endtask

    initial begin
        logic [31:0] s;
        int          cnt, cut;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // Two messages with ready held high.
        out_ready = 1'b1;
        send_dgram(32'h0000_0100, 2, -1, 0, 2);
        wait_drain();
        check_counters("basic");

        // Back-pressure: four held, two dropped, then drained in order.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_dgram(32'h200 + 32'(i), 1, -1, 0, 1);
        drive(1'b0, 8'd0);
        check("held_count", 160'(sb.size()), 160'(Depth));
        check_counters("full");
        out_ready = 1'b1;
        wait_drain();

        // Truncation after message byte 9, then a clean datagram.
        send_dgram(32'h300, 1, 6 + 10, 0, 2);
        check_counters("trunc");
        send_dgram(32'h301, 1, -1, 0, 2);
        wait_drain();

        // Trailing bytes after the last message are ignored.
        send_dgram(32'h302, 1, -1, 5, 2);
        wait_drain();
        check_counters("extra");

        // Sequence gap sequence.
        send_dgram(32'd10, 3, -1, 0, 2);
        send_dgram(32'd14, 1, -1, 0, 2);
        send_dgram(32'd15, 2, -1, 0, 2);
        wait_drain();
        check_counters("gapseq");

        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            s   = ($urandom_range(0, 1) != 0) ? exp_seq : $urandom;
            cnt = $urandom_range(0, 3);
            cut = -1;
            if ($urandom_range(0, 7) == 0) cnt = 200;
            if (cnt == 200 || $urandom_range(0, 3) == 0) cut = $urandom_range(1, 6 + 18 * 3);
            send_dgram(s, cnt, cut, $urandom_range(0, 3), $urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain();
        check_counters("random");

        // Reset while message byte 5 is on the bus.
        send_dgram(32'h400, 2, 6 + 5, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        sb.delete();
        exp_drop = 0; exp_trunc = 0; exp_gap = 0; gap_pulses = 0; exp_valid = 1'b0;
        check_zero("midreset");
        send_dgram(32'h500, 2, -1, 0, 2);
        wait_drain();
        check_counters("postreset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
